// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if
//   Data-memory request/acknowledge bus between the MEM stage and the data memory.
//   One outstanding request: the request side holds dmem_req and its payload until
//   the memory raises dmem_ack for one cycle, with dmem_rdata valid in that cycle.
// Signals
//   dmem_req    request valid, held until ack
//   dmem_we     1 = write
//   dmem_addr   word-aligned byte address {addr[31:2],2'b00}
//   dmem_wstrb  byte lane enables (0 on reads)
//   dmem_wdata  store data replicated into lanes
//   dmem_ack    request done; dmem_rdata valid same cycle
//   dmem_rdata  read word
// Modports: master = MEM stage, slave = data memory.
interface mem_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage
//   MEM pipeline stage: registers each EX result, performs loads/stores on the data
//   memory (one outstanding request), extends load data and presents
//   {rd index, ALU result, load data, access flag} to wb_stage for exactly one cycle
//   per retire. Non-retire cycles present all zeros.
// Parameters
//   WAIT_TIMEOUT  max cycles a dmem request may stay un-acked; 0 = no timeout
// Configuration macro
//   MEM_STAGE_MISALIGN_CHK_EN  when defined, misaligned H/W accesses issue no request
//                              and retire with rd 0 plus an error pulse
// Ports
//   clk_i, reset_ni        clock (rising edge), asynchronous active-low reset
//   ex_*                   instruction presented by EX (valid, rd, ALU result/address,
//                          load/store flags, funct3 size/sign, store data)
//   dmem                   data-memory bus (master side)
//   mem_rd_index_r         rd to wb_stage, 0 when not retiring
//   mem_access_w           1 = wb selects mem_rdata_w
//   mem_wb_alu_result_r    registered ALU result
//   mem_rdata_w            registered, extended load data
//   mem_stall_w            EX must hold; instruction not accepted this cycle
//   mem_err_o              one-cycle pulse on timeout or misaligned access
module mem_access_stage #(
  parameter int unsigned WAIT_TIMEOUT = 255
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                ex_valid_i,
  input  logic [4:0]          ex_rd_index_i,
  input  logic [31:0]         ex_alu_result_i,
  input  logic                ex_mem_read_i,
  input  logic                ex_mem_write_i,
  input  logic [2:0]          ex_funct3_i,
  input  logic [31:0]         ex_store_data_i,
  mem_access_stage_if.master  dmem,
  output logic [4:0]          mem_rd_index_r,
  output logic                mem_access_w,
  output logic [31:0]         mem_wb_alu_result_r,
  output logic [31:0]         mem_rdata_w,
  output logic                mem_stall_w,
  output logic                mem_err_o
);
  localparam int unsigned   CW      = $clog2(WAIT_TIMEOUT + 2);
  localparam logic [CW-1:0] TO_LAST = (WAIT_TIMEOUT == 0) ? '0 : CW'(WAIT_TIMEOUT - 1);

  typedef enum logic {IDLE, REQ} state_t;

  typedef struct packed {
    logic        err;
    logic        acc;
    logic [4:0]  rd;
    logic [31:0] res;
    logic [31:0] rdata;
  } ret_t;

  state_t        state_q, state_d;
  logic [4:0]    op_rd_q;
  logic [31:0]   op_addr_q;
  logic          op_we_q;
  logic [2:0]    op_f3_q;
  logic [31:0]   op_wdata_q;
  logic [CW-1:0] cnt_q;
  ret_t          pend_q, pend_d, comp, newr, sel;
  logic          pend_vld_q, pend_vld_d, comp_vld, newr_vld;
  logic          in_req, is_mem, misalign, accept, timeout;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_ext, st_data;
  logic [3:0]    st_strb;

  assign in_req      = (state_q == REQ);
  assign mem_stall_w = in_req && !dmem.dmem_ack;
  assign accept      = ex_valid_i && !mem_stall_w;
  assign is_mem      = ex_mem_read_i || ex_mem_write_i;
  assign timeout     = (WAIT_TIMEOUT != 0) && in_req && !dmem.dmem_ack && (cnt_q == TO_LAST);

`ifdef MEM_STAGE_MISALIGN_CHK_EN
  assign misalign = is_mem &&
                    ((ex_funct3_i[1:0] == 2'b01 && ex_alu_result_i[0]) ||
                     (ex_funct3_i[1:0] == 2'b10 && ex_alu_result_i[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Lane selection / extension for loads and lane placement for stores
  always_comb begin
    ld_byte = dmem.dmem_rdata[7:0];
    ld_half = op_addr_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    ld_ext  = dmem.dmem_rdata;
    st_strb = '1;
    st_data = op_wdata_q;
    case (op_addr_q[1:0])
      2'd1:    ld_byte = dmem.dmem_rdata[15:8];
      2'd2:    ld_byte = dmem.dmem_rdata[23:16];
      2'd3:    ld_byte = dmem.dmem_rdata[31:24];
      default: ;
    endcase
    case (op_f3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ;
    endcase
    case (op_f3_q[1:0])
      2'b00: begin
        st_strb = 4'b0001 << op_addr_q[1:0];
        st_data = {4{op_wdata_q[7:0]}};
      end
      2'b01: begin
        st_strb = op_addr_q[1] ? 4'b1100 : 4'b0011;
        st_data = {2{op_wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  assign dmem.dmem_req   = in_req;
  assign dmem.dmem_we    = in_req && op_we_q;
  assign dmem.dmem_addr  = in_req ? {op_addr_q[31:2], 2'b00} : '0;
  assign dmem.dmem_wstrb = (in_req && op_we_q) ? st_strb : '0;
  assign dmem.dmem_wdata = (in_req && op_we_q) ? st_data : '0;

  // Retires without a destination (stores, errors, rd 0) present all-zero payloads.
  always_comb begin
    state_d  = state_q;
    comp     = '0;
    comp_vld = 1'b0;
    newr     = '0;
    newr_vld = 1'b0;
    if (in_req) begin
      if (dmem.dmem_ack) begin
        comp_vld = 1'b1;
        state_d  = IDLE;
        if (!op_we_q && op_rd_q != 5'd0) begin
          comp.rd    = op_rd_q;
          comp.acc   = 1'b1;
          comp.res   = op_addr_q;
          comp.rdata = ld_ext;
        end
      end else if (timeout) begin
        comp_vld = 1'b1;
        comp.err = 1'b1;
        state_d  = IDLE;
      end
    end
    if (accept) begin
      if (is_mem && !misalign) begin
        state_d = REQ;
      end else begin
        newr_vld = 1'b1;
        newr.err = misalign;
        if (!misalign && ex_rd_index_i != 5'd0) begin
          newr.rd  = ex_rd_index_i;
          newr.res = ex_alu_result_i;
        end
      end
    end
  end

  // A non-memory op accepted on a load's ack edge would retire in the same cycle
  // as the load. The load wins; the op waits in a one-entry skid slot, which drains
  // ahead of any younger op (younger ops then take the slot in turn).
  always_comb begin
    sel        = comp_vld ? comp : (pend_vld_q ? pend_q : newr);
    pend_vld_d = (comp_vld || pend_vld_q) && newr_vld;
    pend_d     = pend_vld_d ? newr : '0;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q             <= IDLE;
      op_rd_q             <= '0;
      op_addr_q           <= '0;
      op_we_q             <= 1'b0;
      op_f3_q             <= '0;
      op_wdata_q          <= '0;
      cnt_q               <= '0;
      pend_q              <= '0;
      pend_vld_q          <= 1'b0;
      mem_rd_index_r      <= '0;
      mem_access_w        <= 1'b0;
      mem_wb_alu_result_r <= '0;
      mem_rdata_w         <= '0;
      mem_err_o           <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_rd_q    <= ex_rd_index_i;
        op_addr_q  <= ex_alu_result_i;
        op_we_q    <= ex_mem_write_i;
        op_f3_q    <= ex_funct3_i;
        op_wdata_q <= ex_store_data_i;
        cnt_q      <= '0;
      end else if (in_req) begin
        cnt_q <= cnt_q + CW'(1);
      end
      pend_q              <= pend_d;
      pend_vld_q          <= pend_vld_d;
      mem_rd_index_r      <= sel.rd;
      mem_access_w        <= sel.acc;
      mem_wb_alu_result_r <= sel.res;
      mem_rdata_w         <= sel.rdata;
      mem_err_o           <= sel.err;
    end
  end
endmodule
